// File: rtl/riscv_seq_mul_pkg.sv
// riscv_seq_mul shared constants: iteration count, counter width, FSM states.
// Build option: RISCV_SEQ_MUL_RADIX4_EN selects 2 multiplier bits per cycle.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`endif
`ifndef ALU_MULL
`define ALU_MULL 4'd10
`endif
`ifndef ALU_MULH
`define ALU_MULH 4'd11
`endif

package riscv_seq_mul_pkg;

`ifdef RISCV_SEQ_MUL_RADIX4_EN
    localparam int MUL_BITS  = 2;
    localparam int MUL_ITERS = 16;
`else
    localparam int MUL_BITS  = 1;
    localparam int MUL_ITERS = 32;
`endif

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/riscv_seq_mul_dp.sv
// riscv_seq_mul datapath: magnitude latch, shift-add accumulator, final negate.
// Build option: RISCV_SEQ_MUL_RADIX4_EN retires 2 bits/cycle using a 3x multiple.

module riscv_seq_mul_dp
    import riscv_seq_mul_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_last,
    input  logic        i_a_signed,
    input  logic        i_b_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_pp;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_fin;

    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic        r_neg;
    logic [63:0] r_res;

    // -2^31 negates to itself, which is the correct 32-bit magnitude
    assign w_a_neg = i_a_signed & i_a[31];
    assign w_b_neg = i_b_signed & i_b[31];
    assign w_a_mag = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 32'd1) : i_b;

`ifdef RISCV_SEQ_MUL_RADIX4_EN
    logic [63:0] r_mcand3;

    // partial product select: 0, 1x, 2x or precomputed 3x
    always_comb begin
        w_pp = 64'd0;
        unique case (r_mplier[1:0])
            2'd0: w_pp = 64'd0;
            2'd1: w_pp = r_mcand;
            2'd2: w_pp = r_mcand << 1;
            2'd3: w_pp = r_mcand3;
            default: w_pp = 64'd0;
        endcase
    end

    // 3x multiple tracks the shifting multiplicand
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_mcand3 <= 64'd0;
        else if (i_load)
            r_mcand3 <= {32'd0, w_a_mag} + {31'd0, w_a_mag, 1'b0};
        else if (i_step)
            r_mcand3 <= r_mcand3 << 2;
    end
`else
    // partial product select: 0 or 1x
    always_comb begin
        w_pp = 64'd0;
        if (r_mplier[0])
            w_pp = r_mcand;
    end
`endif

    assign w_acc_nxt = r_acc + w_pp;
    assign w_fin     = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;

    // operand latch and one shift-add iteration per step
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_neg    <= 1'b0;
        end else if (i_load) begin
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= 64'd0;
            r_neg    <= w_a_neg ^ w_b_neg;
        end else if (i_step) begin
            r_mcand  <= r_mcand << MUL_BITS;
            r_mplier <= r_mplier >> MUL_BITS;
            r_acc    <= w_acc_nxt;
        end
    end

    // product register updates only on the final iteration
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_res <= 64'd0;
        else if (i_step && i_last)
            r_res <= w_fin;
    end

    assign o_res = r_res;

endmodule

// File: rtl/riscv_seq_mul.sv
// riscv_seq_mul: iterative 32x32->64 multiplier FSM with combinational stall.
// Build option: RISCV_SEQ_MUL_RADIX4_EN halves latency (16 iterations vs 32).

module riscv_seq_mul
    import riscv_seq_mul_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [3:0]  id_alu_op_r,
    input  logic        id_a_signed_r,
    input  logic        id_b_signed_r,
    input  logic [31:0] id_ra_value_r,
    input  logic [31:0] id_rb_value_r,
    output logic [63:0] mul_res_r,
    output logic        ex_stall_mul_w
);

    mul_state_e       r_state;
    mul_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_is_mul;
    logic             w_stall;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    assign w_is_mul = (id_alu_op_r == `ALU_MULL) ||
                      (id_alu_op_r == `ALU_MULH);

    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // next state, stall and datapath controls
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_is_mul) begin
                    w_stall     = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                w_step  = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // iteration counter, cleared at operand latch
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_cnt <= '0;
        else if (w_load)
            r_cnt <= '0;
        else if (w_step)
            r_cnt <= r_cnt + 1'b1;
    end

    // a multiply op seen while reset is asserted must not stall
    assign ex_stall_mul_w = w_stall & rstn_i;

    riscv_seq_mul_dp u_dp (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_last     (w_last),
        .i_a_signed (id_a_signed_r),
        .i_b_signed (id_b_signed_r),
        .i_a        (id_ra_value_r),
        .i_b        (id_rb_value_r),
        .o_res      (mul_res_r)
    );

endmodule

// File: tb/tb_riscv_seq_mul.sv
// Directed self-checking bench for riscv_seq_mul (latency, products, reset abort).
// Latency expectation follows RISCV_SEQ_MUL_RADIX4_EN through the package.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`endif
`ifndef ALU_MULL
`define ALU_MULL 4'd10
`endif
`ifndef ALU_MULH
`define ALU_MULH 4'd11
`endif

module tb_riscv_seq_mul;
    import riscv_seq_mul_pkg::*;

    localparam int LAT = MUL_ITERS + 1;

    logic        clk_i;
    logic        rstn_i;
    logic [3:0]  id_alu_op_r;
    logic        id_a_signed_r;
    logic        id_b_signed_r;
    logic [31:0] id_ra_value_r;
    logic [31:0] id_rb_value_r;
    logic [63:0] mul_res_r;
    logic        ex_stall_mul_w;

    int n_cmp = 0;
    int n_err = 0;

    riscv_seq_mul dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .id_alu_op_r    (id_alu_op_r),
        .id_a_signed_r  (id_a_signed_r),
        .id_b_signed_r  (id_b_signed_r),
        .id_ra_value_r  (id_ra_value_r),
        .id_rb_value_r  (id_rb_value_r),
        .mul_res_r      (mul_res_r),
        .ex_stall_mul_w (ex_stall_mul_w)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge in the cycle the op is presented.
    // Counts stall-high cycles, then checks latency and the product
    // in the DONE cycle. Optionally drops the op back to ALU_ADD.
    task automatic run_mul(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic as, input logic bs,
                           input logic [63:0] exp, input bit rel);
        int cnt;
        id_alu_op_r   = op;
        id_ra_value_r = a;
        id_rb_value_r = b;
        id_a_signed_r = as;
        id_b_signed_r = bs;
        #1;
        cnt = 0;
        while (ex_stall_mul_w === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk_i);
            #1;
        end
        check({tag, "_lat"}, 64'(cnt), 64'(LAT));
        check({tag, "_res"}, mul_res_r, exp);
        if (rel)
            id_alu_op_r = `ALU_ADD;
    endtask

    initial begin
        rstn_i        = 1'b0;
        id_alu_op_r   = `ALU_ADD;
        id_a_signed_r = 1'b0;
        id_b_signed_r = 1'b0;
        id_ra_value_r = 32'd0;
        id_rb_value_r = 32'd0;

        // reset state
        @(negedge clk_i);
        #1;
        check("rst_stall", 64'(ex_stall_mul_w), 64'd0);
        check("rst_res", mul_res_r, 64'd0);
        id_alu_op_r = `ALU_MULL;
        #1;
        check("rst_stall_mul", 64'(ex_stall_mul_w), 64'd0);
        id_alu_op_r = `ALU_ADD;
        @(negedge clk_i);
        rstn_i = 1'b1;

        // 8 x 8 held: two back-to-back runs separated by DONE
        @(negedge clk_i);
        run_mul("u8x8_a", `ALU_MULL, 32'd8, 32'd8, 1'b0, 1'b0,
                64'h40, 1'b0);
        @(negedge clk_i);
        run_mul("u8x8_b", `ALU_MULL, 32'd8, 32'd8, 1'b0, 1'b0,
                64'h40, 1'b1);

        // non-multiply op: no stall, result held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check("add_nostall", 64'(ex_stall_mul_w), 64'd0);
        end
        check("add_hold", mul_res_r, 64'h40);

        @(negedge clk_i);
        run_mul("u7x9", `ALU_MULL, 32'd7, 32'd9, 1'b0, 1'b0,
                64'h3F, 1'b1);

        @(negedge clk_i);
        run_mul("s_m1xm1", `ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF,
                1'b1, 1'b1, 64'h0000000000000001, 1'b1);
        @(negedge clk_i);
        run_mul("u_maxmax", `ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF,
                1'b0, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        @(negedge clk_i);
        run_mul("su_m2x3", `ALU_MULH, 32'hFFFFFFFE, 32'd3,
                1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFA, 1'b1);
        @(negedge clk_i);
        run_mul("s_minxmin", `ALU_MULH, 32'h80000000, 32'h80000000,
                1'b1, 1'b1, 64'h4000000000000000, 1'b1);
        @(negedge clk_i);
        run_mul("s_minx0", `ALU_MULL, 32'h80000000, 32'd0,
                1'b1, 1'b1, 64'd0, 1'b1);
        @(negedge clk_i);
        run_mul("s_m5x0", `ALU_MULL, 32'hFFFFFFFB, 32'd0,
                1'b1, 1'b1, 64'd0, 1'b1);
        @(negedge clk_i);
        run_mul("s_m3x5", `ALU_MULL, 32'hFFFFFFFD, 32'd5,
                1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1, 1'b1);
        @(negedge clk_i);
        run_mul("u_maxx3", `ALU_MULL, 32'hFFFFFFFF, 32'd3,
                1'b0, 1'b0, 64'h00000002FFFFFFFD, 1'b1);
        @(negedge clk_i);
        run_mul("su_minxmax", `ALU_MULH, 32'h80000000, 32'hFFFFFFFF,
                1'b1, 1'b0, 64'h8000000080000000, 1'b1);

        // reset mid-multiply aborts, then the held op restarts
        @(negedge clk_i);
        id_alu_op_r   = `ALU_MULL;
        id_ra_value_r = 32'd7;
        id_rb_value_r = 32'd9;
        id_a_signed_r = 1'b0;
        id_b_signed_r = 1'b0;
        repeat (5) @(negedge clk_i);
        #1;
        check("busy_stall", 64'(ex_stall_mul_w), 64'd1);
        rstn_i = 1'b0;
        #1;
        check("abort_stall", 64'(ex_stall_mul_w), 64'd0);
        check("abort_res", mul_res_r, 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        run_mul("restart", `ALU_MULL, 32'd7, 32'd9, 1'b0, 1'b0,
                64'h3F, 1'b1);

        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
